// File: rtl/axi_read_responder.sv
// axi_read_responder: queued AXI read responder serving bursts from a preloadable word store after a fixed latency.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module axi_read_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [`ADDR_WIDTH-1:0]       ARADDR,
  input  logic [3:0]                   ARLEN,
  input  logic [3:0]                   ARID,
  input  logic                         ARVALID,
  output logic                         ARREADY,
  output logic [`DATA_WIDTH-1:0]       RDATA,
  output logic [3:0]                   RID,
  output logic                         RLAST,
  output logic                         RVALID,
  input  logic                         RREADY,
  input  logic                         init_we,
  input  logic [$clog2(MEM_WORDS)-1:0] init_addr,
  input  logic [`DATA_WIDTH-1:0]       init_wdata
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int LW = LATENCY > 0 ? $clog2(LATENCY + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_LATENCY, S_BURST} state_t;
  state_t state, state_n;
  logic [`DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [IW-1:0] q_addr [QUEUE_DEPTH];
  logic [3:0]    q_len  [QUEUE_DEPTH];
  logic [3:0]    q_id   [QUEUE_DEPTH];
  logic [QW:0]   head, tail;
  logic [IW-1:0] b_addr, addr_n;
  logic [3:0]    b_rem, rem_n, b_id, id_n;
  logic [LW-1:0] cnt, cnt_n;
  logic          full, empty, push, pop, last_acc;
  logic          unused;
  assign unused   = ^{ARADDR[1:0], ARADDR[`ADDR_WIDTH-1:IW+2]};
  assign empty    = head == tail;
  assign full     = (head[QW-1:0] == tail[QW-1:0]) && (head[QW] != tail[QW]);
  assign ARREADY  = ~full;
  assign push     = ARVALID & ~full;
  assign RVALID   = state == S_BURST;
  assign RDATA    = mem[b_addr];
  assign RID      = b_id;
  assign RLAST    = RVALID && b_rem == 4'd1;
  assign last_acc = RLAST && RREADY;
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_wdata;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail[QW-1:0]] <= ARADDR[2 +: IW];
      q_len[tail[QW-1:0]]  <= ARLEN == 4'd0 ? 4'd1 : ARLEN;
      q_id[tail[QW-1:0]]   <= ARID;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      head   <= '0;
      tail   <= '0;
      cnt    <= '0;
      b_addr <= '0;
      b_rem  <= '0;
      b_id   <= '0;
    end else begin
      state  <= state_n;
      head   <= pop ? head + 1'b1 : head;
      tail   <= push ? tail + 1'b1 : tail;
      cnt    <= cnt_n;
      b_addr <= addr_n;
      b_rem  <= rem_n;
      b_id   <= id_n;
    end
  end
  // A pop on the final accepted beat starts the next request without an idle cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = b_addr;
    rem_n   = b_rem;
    id_n    = b_id;
    pop     = 1'b0;
    if (state == S_LATENCY) begin
      cnt_n   = cnt - LW'(1);
      state_n = cnt == LW'(1) ? S_BURST : S_LATENCY;
    end
    if (RVALID && RREADY) begin
      addr_n  = b_addr + IW'(1);
      rem_n   = b_rem - 4'd1;
      state_n = b_rem == 4'd1 ? S_IDLE : S_BURST;
    end
    if ((state == S_IDLE || last_acc) && !empty) begin
      pop     = 1'b1;
      addr_n  = q_addr[head[QW-1:0]];
      rem_n   = q_len[head[QW-1:0]];
      id_n    = q_id[head[QW-1:0]];
      cnt_n   = LW'(LATENCY);
      state_n = LATENCY == 0 ? S_BURST : S_LATENCY;
    end
  end
`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (rst_n && pop) stats_event("axi_resp_burst");
  end
`endif
endmodule

// File: tb/tb_axi_read_responder.sv
// tb_axi_read_responder: directed checks of latency, stalls, queue fill, wrap, zero-latency and mid-burst reset.
module tb_axi_read_responder;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] ARADDR = 0;
  logic [3:0]  ARLEN = 0, ARID = 0;
  logic        ARVALID = 0, ARREADY;
  logic [31:0] RDATA;
  logic [3:0]  RID;
  logic        RLAST, RVALID;
  logic        RREADY = 1;
  logic [31:0] z_araddr = 0;
  logic [3:0]  z_arlen = 0, z_arid = 0;
  logic        z_arvalid = 0, z_arready;
  logic [31:0] z_rdata;
  logic [3:0]  z_rid;
  logic        z_rlast, z_rvalid;
  logic        init_we = 0;
  logic [9:0]  init_addr = 0;
  logic [31:0] init_wdata = 0;
  logic [31:0] model [1024];
  int          n_cmp = 0, n_err = 0;
  int          first;

  always #5 clk = ~clk;

  axi_read_responder dut (
    .clk(clk), .rst_n(rst_n), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RID(RID),
    .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .init_we(init_we),
    .init_addr(init_addr), .init_wdata(init_wdata)
  );

  axi_read_responder #(.LATENCY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .ARADDR(z_araddr), .ARLEN(z_arlen), .ARID(z_arid),
    .ARVALID(z_arvalid), .ARREADY(z_arready), .RDATA(z_rdata), .RID(z_rid),
    .RLAST(z_rlast), .RVALID(z_rvalid), .RREADY(1'b1), .init_we(init_we),
    .init_addr(init_addr), .init_wdata(init_wdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int word, input logic [31:0] val);
    init_we = 1;
    init_addr = 10'(word);
    init_wdata = val;
    model[word] = val;
    @(negedge clk);
    init_we = 0;
  endtask

  task automatic ar_send(input int word, input logic [3:0] len, input logic [3:0] id);
    int t = 0;
    ARADDR = 32'(word * 4);
    ARLEN = len;
    ARID = id;
    ARVALID = 1;
    while (!ARREADY && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ARREADY) check("ar_timeout", 32'(ARREADY), 1);
    @(negedge clk);
    ARVALID = 0;
  endtask

  // mode 0: RREADY held high; mode 1: RREADY pattern 1,0,0 repeating.
  task automatic recv(input string tag, input int start, input int beats,
                      input logic [3:0] id, input int mode, output int first_t);
    int k = 0, t = 0;
    logic held = 0;
    logic [31:0] hdat = 0;
    logic [5:0]  hctl = 0;
    first_t = -1;
    while (k < beats && t < 200) begin
      RREADY = (mode == 0) || (t % 3 == 0);
      if (held) begin
        check({tag, " hold_data"}, RDATA, hdat);
        check({tag, " hold_ctl"}, {26'd0, RVALID, RLAST, RID}, {26'd0, hctl});
      end
      if (RVALID && first_t < 0) first_t = t;
      held = RVALID && !RREADY;
      hdat = RDATA;
      hctl = {RVALID, RLAST, RID};
      if (RVALID && RREADY) begin
        check({tag, " data"}, RDATA, model[(start + k) % 1024]);
        check({tag, " id"}, 32'(RID), 32'(id));
        check({tag, " last"}, 32'(RLAST), 32'(k == beats - 1));
        k++;
      end
      @(negedge clk);
      t++;
    end
    if (k < beats) check({tag, " beats"}, k, beats);
    RREADY = 1;
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    rst_n = 1;
    check("rst_rvalid", 32'(RVALID), 0);
    check("rst_rlast", 32'(RLAST), 0);
    check("rst_rid", 32'(RID), 0);
    check("rst_arready", 32'(ARREADY), 1);
    check("rst_z_rvalid", 32'(z_rvalid), 0);
    for (int i = 0; i < 32; i++)
      preload(i, (i >= 16 && i < 20) ? 32'hA0 + 32'(i - 16) : 32'hC000_0000 + 32'(i));
    for (int i = 1020; i < 1024; i++) preload(i, 32'hE000_0000 + 32'(i));

    RREADY = 1;
    ar_send(16, 4, 2);
    recv("lat4", 16, 4, 2, 0, first);
    check("lat4 first", first, 5);
    check("lat4 after", 32'(RVALID), 0);

    ar_send(16, 4, 2);
    recv("stall", 16, 4, 2, 1, first);
    check("stall after", 32'(RVALID), 0);

    RREADY = 0;
    ar_send(16, 4, 1);
    ar_send(4, 2, 3);
    ar_send(8, 1, 5);
    ar_send(12, 0, 7);
    ar_send(16, 3, 9);
    check("q full", 32'(ARREADY), 0);
    repeat (3) @(negedge clk);
    check("q full hold", 32'(ARREADY), 0);
    check("q rvalid wait", 32'(RVALID), 1);
    recv("q0", 16, 4, 1, 0, first);
    check("q ready after b0", 32'(ARREADY), 1);
    recv("q1", 4, 2, 3, 0, first);
    recv("q2", 8, 1, 5, 0, first);
    recv("q3 len0", 12, 1, 7, 0, first);
    recv("q4", 16, 3, 9, 0, first);
    check("q drained", 32'(RVALID), 0);

    ar_send(1022, 4, 11);
    recv("wrap", 1022, 4, 11, 0, first);

    z_araddr = 0; z_arlen = 2; z_arid = 1; z_arvalid = 1;
    check("z ready", 32'(z_arready), 1);
    @(negedge clk);
    z_araddr = 32; z_arlen = 1; z_arid = 4;
    check("z idle", 32'(z_rvalid), 0);
    @(negedge clk);
    z_arvalid = 0;
    check("z b0 v", 32'(z_rvalid), 1);
    check("z b0 d", z_rdata, model[0]);
    check("z b0 ctl", {z_rlast, z_rid}, {1'b0, 4'd1});
    @(negedge clk);
    check("z b1 v", 32'(z_rvalid), 1);
    check("z b1 d", z_rdata, model[1]);
    check("z b1 ctl", {z_rlast, z_rid}, {1'b1, 4'd1});
    @(negedge clk);
    check("z c0 v", 32'(z_rvalid), 1);
    check("z c0 d", z_rdata, model[8]);
    check("z c0 ctl", {z_rlast, z_rid}, {1'b1, 4'd4});
    @(negedge clk);
    check("z done", 32'(z_rvalid), 0);

    ar_send(16, 4, 2);
    t = 0;
    while (!RVALID && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("rst mid first", 32'(RVALID), 1);
    @(negedge clk);
    check("rst mid beat2", RDATA, model[17]);
    rst_n = 0;
    @(negedge clk);
    check("rst mid rvalid", 32'(RVALID), 0);
    check("rst mid arready", 32'(ARREADY), 1);
    check("rst mid ctl", {RLAST, RID}, 5'd0);
    rst_n = 1;
    ar_send(20, 2, 6);
    recv("post rst", 20, 2, 6, 0, first);
    check("post rst first", first, 5);
    check("post rst after", 32'(RVALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
